// File: rtl/shot_clock_alarm_pkg.sv
// Shared definitions for the shot-clock alarm block.
//   state_t          : alarm FSM state (IDLE / WARN / BUZZ)
//   BCD_MAX          : largest legal BCD digit
//   WARN_SEC_DEF     : default warning window in seconds
//   BUZZ_TICKS_DEF   : default buzzer burst length in ticks
//   bcd_pair_valid() : 1 when both digits are legal BCD
package shot_clock_alarm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WARN = 2'd1,
    BUZZ = 2'd2
  } state_t;

  localparam logic [3:0] BCD_MAX        = 4'd9;
  localparam int         WARN_SEC_DEF   = 5;
  localparam int         BUZZ_TICKS_DEF = 3;

  function automatic logic bcd_pair_valid(input logic [3:0] hi, input logic [3:0] lo);
    return (hi <= BCD_MAX) && (lo <= BCD_MAX);
  endfunction

endpackage

// File: rtl/shot_clock_alarm_bcd_counter2.sv
// Two-digit BCD incrementer, 00..99 with wrap back to 00.
//   clkout : tick clock, rising edge
//   clr    : async active-low clear
//   en     : count by one on this edge
//   tens   : BCD tens digit (registered)
//   units  : BCD units digit (registered)
module bcd_counter2
  import shot_clock_alarm_pkg::*;
(
  input  logic       clkout,
  input  logic       clr,
  input  logic       en,
  output logic [3:0] tens,
  output logic [3:0] units
);

  always_ff @(posedge clkout or negedge clr) begin
    if (!clr) begin
      tens  <= 4'd0;
      units <= 4'd0;
    end else if (en) begin
      if (units == BCD_MAX) begin
        units <= 4'd0;
        tens  <= (tens == BCD_MAX) ? 4'd0 : tens + 4'd1;
      end else begin
        units <= units + 4'd1;
      end
    end
  end

endmodule

// File: rtl/shot_clock_alarm.sv
// Shot-clock alarm: watches the countdown digits, blinks a warning LED in the
// last WARN_SEC seconds, sounds a BUZZ_TICKS-long buzzer burst on expiry,
// counts violations in BCD and flips possession on every violation.
//   clkout     : 1 Hz tick, rising edge
//   clr        : async active-low reset
//   tens/units : BCD countdown digits
//   paused     : countdown frozen
//   buzzer     : buzzer drive
//   warn_led   : blinking warning LED
//   viol_tens/viol_units : BCD violation count
//   possession : 0 = home, 1 = away
module shot_clock_alarm
  import shot_clock_alarm_pkg::*;
#(
  parameter int WARN_SEC   = WARN_SEC_DEF,
  parameter int BUZZ_TICKS = BUZZ_TICKS_DEF
) (
  input  logic       clkout,
  input  logic       clr,
  input  logic [3:0] tens,
  input  logic [3:0] units,
  input  logic       paused,
  output logic       buzzer,
  output logic       warn_led,
  output logic [3:0] viol_tens,
  output logic [3:0] viol_units,
  output logic       possession
);

  localparam logic [2:0] BT = 3'(BUZZ_TICKS);

  state_t     state;
  logic       prev_zero;
  logic [2:0] bcnt;

  logic       valid, is_zero, in_warn, expiry;
  logic [6:0] val;

  // Illegal digits count as "not zero, not in range" so garbage never fires.
  assign valid   = bcd_pair_valid(tens, units);
  assign val     = 7'(tens) * 7'd10 + 7'(units);
  assign is_zero = valid && (val == 7'd0);
  assign in_warn = valid && (val >= 7'd1) && (val <= 7'(WARN_SEC));
  // Edge-detect on reaching 00 so a held 00 fires once; a paused 00 never fires.
  assign expiry  = is_zero && !prev_zero && !paused;

  bcd_counter2 u_viol (
    .clkout (clkout),
    .clr    (clr),
    .en     (expiry),
    .tens   (viol_tens),
    .units  (viol_units)
  );

  always_ff @(posedge clkout or negedge clr) begin
    if (!clr) begin
      state      <= IDLE;
      prev_zero  <= 1'b1;
      bcnt       <= 3'd0;
      buzzer     <= 1'b0;
      warn_led   <= 1'b0;
      possession <= 1'b0;
    end else begin
      prev_zero <= is_zero;
      if (expiry) possession <= ~possession;

      case (state)
        IDLE: begin
          if (expiry) begin
            state    <= BUZZ;
            buzzer   <= 1'b1;
            bcnt     <= BT;
            warn_led <= 1'b0;
          end else if (in_warn && !paused) begin
            state    <= WARN;
            warn_led <= 1'b1;
          end
        end
        WARN: begin
          if (expiry) begin
            state    <= BUZZ;
            buzzer   <= 1'b1;
            bcnt     <= BT;
            warn_led <= 1'b0;
          end else if (!in_warn || paused) begin
            state    <= IDLE;
            warn_led <= 1'b0;
          end else begin
            warn_led <= ~warn_led;
          end
        end
        BUZZ: begin
          warn_led <= 1'b0;
          // A fresh expiry mid-burst reloads the full burst length.
          if (expiry) begin
            bcnt <= BT;
          end else if (bcnt <= 3'd1) begin
            state  <= IDLE;
            buzzer <= 1'b0;
            bcnt   <= 3'd0;
          end else begin
            bcnt <= bcnt - 3'd1;
          end
        end
        default: begin
          state    <= IDLE;
          buzzer   <= 1'b0;
          warn_led <= 1'b0;
          bcnt     <= 3'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shot_clock_alarm.sv
// Bench for shot_clock_alarm: literal vector table for the directed corner
// cases, plus a behavioural model for countdown, wrap and random phases.
module tb_shot_clock_alarm;

  localparam int WS = 5;
  localparam int BT = 3;

  logic       clkout, clr, paused;
  logic [3:0] tens, units;
  logic       buzzer, warn_led, possession;
  logic [3:0] viol_tens, viol_units;

  shot_clock_alarm #(.WARN_SEC(WS), .BUZZ_TICKS(BT)) dut (
    .clkout     (clkout),
    .clr        (clr),
    .tens       (tens),
    .units      (units),
    .paused     (paused),
    .buzzer     (buzzer),
    .warn_led   (warn_led),
    .viol_tens  (viol_tens),
    .viol_units (viol_units),
    .possession (possession)
  );

  initial clkout = 1'b0;
  always #5 clkout = ~clkout;

  int pass_cnt = 0;
  int total    = 0;

  // Behavioural model: violation count as an integer, burst as ticks remaining.
  bit m_prevz, m_led, m_warning, m_poss;
  int m_rem, m_cnt;

  task automatic model_reset();
    m_prevz = 1; m_led = 0; m_warning = 0; m_poss = 0; m_rem = 0; m_cnt = 0;
  endtask

  task automatic model_step(input logic [3:0] t, input logic [3:0] u, input logic p);
    bit ok, zero, rng, fire;
    int v;
    ok   = (t <= 9) && (u <= 9);
    v    = t * 10 + u;
    zero = ok && (v == 0);
    rng  = ok && (v >= 1) && (v <= WS);
    fire = zero && !m_prevz && !p;
    m_prevz = zero;
    if (fire) begin
      m_cnt = (m_cnt + 1) % 100;
      m_poss = !m_poss;
      m_rem = BT; m_led = 0; m_warning = 0;
    end else if (m_rem > 0) begin
      m_rem = m_rem - 1; m_led = 0; m_warning = 0;
    end else if (rng && !p) begin
      m_led = m_warning ? !m_led : 1'b1;
      m_warning = 1;
    end else begin
      m_led = 0; m_warning = 0;
    end
  endtask

  function automatic logic [10:0] model_exp();
    return {(m_rem > 0), m_led, 4'(m_cnt / 10), 4'(m_cnt % 10), m_poss};
  endfunction

  task automatic check(input string name, input logic [10:0] exp);
    logic [10:0] got;
    got = {buzzer, warn_led, viol_tens, viol_units, possession};
    total++;
    if (got !== exp)
      $display("FAIL %s: got buz/led/vt/vu/poss=%b/%b/%h/%h/%b required %b/%b/%h/%h/%b",
               name, got[10], got[9], got[8:5], got[4:1], got[0],
               exp[10], exp[9], exp[8:5], exp[4:1], exp[0]);
    else pass_cnt++;
  endtask

  // Drive on the falling edge, let one rising edge happen, sample 1 ns later.
  task automatic tick(input logic [3:0] t, input logic [3:0] u, input logic p);
    @(negedge clkout);
    clr = 1'b1; tens = t; units = u; paused = p;
    @(posedge clkout);
    #1;
    model_step(t, u, p);
  endtask

  typedef struct {
    logic [3:0] t, u;
    logic       p;
    logic       buz, led;
    logic [3:0] vt, vu;
    logic       poss;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] t, input logic [3:0] u, input logic p,
                              input logic buz, input logic led, input logic [3:0] vt,
                              input logic [3:0] vu, input logic poss);
    vec_t r;
    r.t = t; r.u = u; r.p = p; r.buz = buz; r.led = led; r.vt = vt; r.vu = vu; r.poss = poss;
    return r;
  endfunction

  vec_t tbl[$];

  initial begin
    // Starts right after the 23..00 countdown: burst running, viol 01, away.
    tbl.push_back(mk(0,0,0, 1,0,0,1,1)); // held 00, burst tick 2
    tbl.push_back(mk(0,0,0, 1,0,0,1,1)); // burst tick 3
    tbl.push_back(mk(0,0,0, 0,0,0,1,1)); // burst over, no refire
    tbl.push_back(mk(0,0,0, 0,0,0,1,1)); // fifth 00, still quiet
    tbl.push_back(mk(0,4,0, 0,1,0,1,1)); // enter warning
    tbl.push_back(mk(0,3,0, 0,0,0,1,1)); // blink
    tbl.push_back(mk(0,3,1, 0,0,0,1,1)); // paused: warning drops
    tbl.push_back(mk(0,3,1, 0,0,0,1,1));
    tbl.push_back(mk(0,3,1, 0,0,0,1,1));
    tbl.push_back(mk(0,3,1, 0,0,0,1,1));
    tbl.push_back(mk(0,2,0, 0,1,0,1,1)); // resume: blink restarts
    tbl.push_back(mk(0,1,0, 0,0,0,1,1));
    tbl.push_back(mk(0,0,0, 1,0,0,2,0)); // expiry 2
    tbl.push_back(mk(0,1,0, 1,0,0,2,0)); // in burst, no blink
    tbl.push_back(mk(0,0,0, 1,0,0,3,1)); // expiry 3 reloads burst
    tbl.push_back(mk(0,0,0, 1,0,0,3,1));
    tbl.push_back(mk(0,0,0, 1,0,0,3,1));
    tbl.push_back(mk(0,0,0, 0,0,0,3,1)); // ends 3 ticks after second 00
    tbl.push_back(mk(0,1,0, 0,1,0,3,1)); // warning at 01
    tbl.push_back(mk(0,0,1, 0,0,0,3,1)); // 00 while paused: no fire
    tbl.push_back(mk(0,0,0, 0,0,0,3,1)); // still 00 after unpause: no fire
    tbl.push_back(mk(4'hA,0,0, 0,0,0,3,1)); // invalid: nothing
    tbl.push_back(mk(4'hA,0,0, 0,0,0,3,1));
    tbl.push_back(mk(0,5,0, 0,1,0,3,1)); // upper edge of window
    tbl.push_back(mk(0,6,0, 0,0,0,3,1)); // just outside
    tbl.push_back(mk(0,5,0, 0,1,0,3,1));
    tbl.push_back(mk(0,4'hA,0, 0,0,0,3,1)); // invalid units leaves warning
    tbl.push_back(mk(0,0,0, 1,0,0,4,0)); // invalid counted as non-zero: fires

    clr = 1'b0; tens = 4'd0; units = 4'd0; paused = 1'b0;
    model_reset();
    #12;
    check("reset", 11'b0);

    // Full countdown 23..00.
    for (int v = 23; v >= 0; v--) begin
      tick(4'(v / 10), 4'(v % 10), 1'b0);
      check($sformatf("countdown_%0d", v), model_exp());
    end

    foreach (tbl[i]) begin
      tick(tbl[i].t, tbl[i].u, tbl[i].p);
      check($sformatf("vec_%0d", i),
            {tbl[i].buz, tbl[i].led, tbl[i].vt, tbl[i].vu, tbl[i].poss});
    end

    // Asynchronous clear between edges during a burst.
    @(negedge clkout);
    clr = 1'b0;
    #1;
    check("async_clr_mid_burst", 11'b0);
    model_reset();

    // 99 expiries, then the wrapping 100th.
    for (int n = 0; n < 99; n++) begin
      tick(0, 1, 0);
      check("wrap_run_01", model_exp());
      tick(0, 0, 0);
      check("wrap_run_00", model_exp());
    end
    check("viol_99", {1'b1, 1'b0, 4'd9, 4'd9, 1'b1});
    tick(0, 1, 0);
    tick(0, 0, 0);
    check("viol_wrap_00", {1'b1, 1'b0, 4'd0, 4'd0, 1'b0});

    // Random phase, biased toward the interesting region near zero.
    for (int n = 0; n < 500; n++) begin
      logic [3:0] t, u;
      logic p;
      case ($urandom_range(0, 7))
        0, 1:    begin t = 0; u = 0; end
        2, 3, 4: begin t = 0; u = 4'($urandom_range(0, 9)); end
        5:       begin t = 4'($urandom_range(1, 2)); u = 4'($urandom_range(0, 9)); end
        6:       begin t = 4'($urandom_range(0, 15)); u = 4'($urandom_range(0, 15)); end
        default: begin t = 0; u = 4'($urandom_range(10, 15)); end
      endcase
      p = ($urandom_range(0, 5) == 0);
      tick(t, u, p);
      check("random", model_exp());
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/shot_clock_alarm.md
Name: shot_clock_alarm

Overview:
- Downstream consumer of the 24 s shot-clock countdown stage, clocked by the same 1 Hz tick.
- Watches the two BCD digits the countdown produces and raises a last-seconds warning blink.
- Fires a timed buzzer burst on expiry (00), counts shot-clock violations as two BCD digits, and toggles a possession flag on every violation.
- Outputs feed the buzzer driver, a warning LED and a spare pair of seven-segment digits.

Parameters:
- WARN_SEC, 5, warning active while displayed value is 1..WARN_SEC (decimal, 1..23).
- BUZZ_TICKS, 3, number of clkout ticks the buzzer stays on after expiry (1..7).

Ports:
- clkout  in   1  1 Hz tick clock, rising edge active.
- clr     in   1  reset, asynchronous, active-low.
- tens    in   4  BCD tens digit of countdown.
- units   in   4  BCD units digit of countdown.
- paused  in   1  1 = countdown frozen.
- buzzer  out  1  1 = buzzer on.
- warn_led out 1  blinking warning LED.
- viol_tens out 4 BCD tens of violation count.
- viol_units out 4 BCD units of violation count.
- possession out 1 team in possession, 0 = home, 1 = away.

Behaviour:
- Reset (clr=0, async): buzzer=0, warn_led=0, viol_tens=0, viol_units=0, possession=0, state=IDLE, prev_zero=1, buzz counter=0.
- Input validity: the value is valid iff tens<=9 and units<=9. If invalid, it is treated as "not zero, not in warn range". An invalid value still updates prev_zero to 0.
- Value V = tens*10+units, computed combinationally from the inputs sampled at each rising clkout.
- Expiry event: V==0 and prev_zero==0 and paused==0. prev_zero <= (V==0) every tick. A value held at 00 fires only once; a value held at 00 while paused does not fire.
- States are IDLE, WARN and BUZZ.
  - IDLE: if expiry, go to BUZZ. Else if 1<=V<=WARN_SEC and !paused, go to WARN.
  - WARN: warn_led toggles every tick. If expiry, go to BUZZ. If V out of range or paused, go to IDLE with warn_led<=0 on that edge.
  - BUZZ: buzzer=1 for exactly BUZZ_TICKS ticks, counted from the expiry edge. Then return to IDLE with buzzer<=0. While in BUZZ, warn_led=0.
- Buzzer latency: buzzer rises on the same clkout edge that samples V==0.
- Simultaneous events in BUZZ:
  - A new expiry restarts the buzz counter to BUZZ_TICKS.
  - That expiry is still counted as a violation and still toggles possession.
- Violation counter: increments by 1 on each expiry edge, as 2-digit BCD (units 9→0 carries into tens). 99 wraps to 00.
- possession: inverts on each expiry edge.
- All outputs are registered. No combinational path from inputs to outputs.
- Reset mid-burst clears the buzzer and FSM immediately, without waiting for a clock edge.

Decomposition:
- Shared package holds:
  - State encoding constants (IDLE=2'd0, WARN=2'd1, BUZZ=2'd2).
  - BCD_MAX=4'd9.
  - Default WARN_SEC and BUZZ_TICKS.
- One sub-module, bcd_counter2: 2-digit BCD incrementer with enable, async active-low clear, and 99→00 wrap. It is reused for the violation count.
- FSM, buzz counter and expiry detection live in the top.

Test Plan:
- Reset then countdown 23→00 unpaused, WARN_SEC=5:
  - warn_led toggles on ticks at 05..01.
  - On the 00 edge, buzzer=1 for 3 ticks and warn_led=0.
  - viol = 0,1 and possession=1.
- Countdown reaches 03, then paused=1 for 4 ticks:
  - warn_led=0 and state IDLE while paused.
  - Resume restarts the blink at 02.
  - No violation is counted during the pause.
- Hold tens/units at 0,0 for 5 ticks:
  - Exactly one buzzer burst of 3 ticks.
  - viol increments only once.
- Drive 99 expiries (alternating 01/00):
  - viol reads 9,9.
  - The 100th expiry reads 0,0.
  - possession ends at 0.
- Second expiry arrives during the burst (00,01,00 sequence):
  - Buzzer stays high, counter reloads, and it ends 3 ticks after the second 00.
  - viol +2.
- Assert clr low mid-burst between edges:
  - buzzer, warn_led, viol and possession clear to 0 immediately.
  - Invalid input tens=4'hA, units=0 gives no expiry and no warning.
